// File: rtl/interrupt_state_controller_pkg.sv
// Shared encodings for the interrupt save/restore sequencer. The ALU stage
// compares stateType/saveStateCounter against these same constants.
package interrupt_state_controller_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_RESTORE = 3'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_IDLE       = 3'd0;
    localparam logic [CNT_W-1:0] CNT_FIRST      = 3'd1;
    localparam logic [CNT_W-1:0] CNT_SECOND     = 3'd2;
    localparam logic [CNT_W-1:0] CNT_FLAG_LOAD  = 3'd3;
    localparam logic [CNT_W-1:0] CNT_LAST       = 3'd4;

endpackage

// File: rtl/interrupt_state_controller_if.sv
// Bundle of request, stack-memory, SP and PC-redirect signals between the
// interrupt sequencer (master) and the surrounding pipeline (slave).
interface interrupt_state_controller_if;
    import interrupt_state_controller_pkg::*;

    logic               interrupt;
    logic               rti_req;
    logic [15:0]        pc_current;
    logic [2:0]         flags;
    logic [15:0]        sp;
    logic [15:0]        mem_data_in;

    logic [STATE_W-1:0] stateType;
    logic [CNT_W-1:0]   saveStateCounter;
    logic               stall;
    logic [15:0]        mem_addr;
    logic [15:0]        mem_wdata;
    logic               mem_write;
    logic               mem_read;
    logic [15:0]        sp_next;
    logic               sp_we;
    logic               pc_load;
    logic [15:0]        pc_value;

    modport master (
        input  interrupt, rti_req, pc_current, flags, sp, mem_data_in,
        output stateType, saveStateCounter, stall,
               mem_addr, mem_wdata, mem_write, mem_read,
               sp_next, sp_we, pc_load, pc_value
    );

    modport slave (
        output interrupt, rti_req, pc_current, flags, sp, mem_data_in,
        input  stateType, saveStateCounter, stall,
               mem_addr, mem_wdata, mem_write, mem_read,
               sp_next, sp_we, pc_load, pc_value
    );

endinterface

// File: rtl/interrupt_state_controller.sv
// Four-step interrupt state-save / RTI state-restore sequencer. Every output
// is decoded from registered state so no input reaches an output directly.
module interrupt_state_controller
    import interrupt_state_controller_pkg::*;
#(
    parameter logic [15:0] INT_VECTOR = 16'h0020
) (
    input  logic                          clk,
    input  logic                          rst,
    interrupt_state_controller_if.master  bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               int_pend_q, rti_pend_q;
    logic [15:0]        saved_pc_q;
    logic [2:0]         saved_flags_q;
    logic [15:0]        sp_q;
    logic [15:0]        pc_restore_q;

    logic               start_save, start_rti;

    logic               mem_write_c, mem_read_c, sp_we_c, pc_load_c;
    logic [15:0]        mem_addr_c, mem_wdata_c, sp_next_c, pc_value_c;

    // Interrupt always wins when both requests are pending in IDLE.
    assign start_save = (state_q == ST_IDLE) && int_pend_q;
    assign start_rti  = (state_q == ST_IDLE) && !int_pend_q && rti_pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_IDLE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (start_save) begin
                state_d = ST_SAVE;
                cnt_d   = CNT_FIRST;
            end else if (start_rti) begin
                state_d = ST_RESTORE;
                cnt_d   = CNT_FIRST;
            end
        end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_IDLE;
        end else begin
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_comb begin
        mem_write_c = 1'b0;
        mem_read_c  = 1'b0;
        mem_addr_c  = 16'h0000;
        mem_wdata_c = 16'h0000;
        sp_next_c   = 16'h0000;
        sp_we_c     = 1'b0;
        pc_load_c   = 1'b0;
        pc_value_c  = 16'h0000;
        case (state_q)
            ST_SAVE: begin
                case (cnt_q)
                    CNT_FIRST: begin
                        mem_write_c = 1'b1;
                        mem_addr_c  = sp_q;
                        mem_wdata_c = {13'b0, saved_flags_q};
                        sp_next_c   = sp_q - 16'd1;
                        sp_we_c     = 1'b1;
                    end
                    CNT_SECOND: begin
                        mem_write_c = 1'b1;
                        mem_addr_c  = sp_q;
                        mem_wdata_c = saved_pc_q;
                        sp_next_c   = sp_q - 16'd1;
                        sp_we_c     = 1'b1;
                    end
                    CNT_FLAG_LOAD: begin
                        pc_load_c   = 1'b1;
                        pc_value_c  = INT_VECTOR;
                    end
                    default: ;
                endcase
            end
            ST_RESTORE: begin
                case (cnt_q)
                    CNT_FIRST, CNT_SECOND: begin
                        mem_read_c  = 1'b1;
                        mem_addr_c  = sp_q + 16'd1;
                        sp_next_c   = sp_q + 16'd1;
                        sp_we_c     = 1'b1;
                    end
                    CNT_FLAG_LOAD: begin
                        pc_load_c   = 1'b1;
                        pc_value_c  = pc_restore_q;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Internal SP copy follows sp_next so the sequence never looks at bus.sp
    // after its starting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pend_q    <= 1'b0;
            rti_pend_q    <= 1'b0;
            saved_pc_q    <= 16'h0000;
            saved_flags_q <= 3'b000;
            sp_q          <= 16'h0000;
            pc_restore_q  <= 16'h0000;
        end else begin
            int_pend_q <= bus.interrupt | (int_pend_q & ~start_save);
            rti_pend_q <= bus.rti_req   | (rti_pend_q & ~start_rti);
            if (start_save || start_rti) begin
                saved_pc_q    <= bus.pc_current;
                saved_flags_q <= bus.flags;
                sp_q          <= bus.sp;
            end else if (sp_we_c) begin
                sp_q          <= sp_next_c;
            end
            // Saved PC read in cnt1 arrives on the bus during cnt2.
            if (state_q == ST_RESTORE && cnt_q == CNT_SECOND)
                pc_restore_q <= bus.mem_data_in;
        end
    end

    assign bus.stateType        = state_q;
    assign bus.saveStateCounter = cnt_q;
    assign bus.stall            = (state_q != ST_IDLE);
    assign bus.mem_write        = mem_write_c;
    assign bus.mem_read         = mem_read_c;
    assign bus.mem_addr         = mem_addr_c;
    assign bus.mem_wdata        = mem_wdata_c;
    assign bus.sp_next          = sp_next_c;
    assign bus.sp_we            = sp_we_c;
    assign bus.pc_load          = pc_load_c;
    assign bus.pc_value         = pc_value_c;

endmodule

// File: tb/tb_interrupt_state_controller.sv
// Directed bench for the interrupt save/restore sequencer, with a small
// stack memory, SP register and PC register modelled around the block.
module tb_interrupt_state_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [15:0] mem [0:65535];
    logic        lat_wr, lat_rd, lat_spwe, lat_pcl;
    logic [15:0] lat_addr, lat_wdata, lat_spn, lat_pcv;

    interrupt_state_controller_if bus ();

    interrupt_state_controller #(.INT_VECTOR(16'h0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_step(input string tag, input logic [2:0] st, input logic [2:0] cnt,
                            input logic mw, input logic mr, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [15:0] spn, input logic spwe,
                            input logic pcl, input logic [15:0] pcv);
        chk({tag, ".stateType"}, {13'b0, bus.stateType}, {13'b0, st});
        chk({tag, ".cnt"},       {13'b0, bus.saveStateCounter}, {13'b0, cnt});
        chk({tag, ".stall"},     {15'b0, bus.stall}, {15'b0, (st != 3'd0)});
        chk({tag, ".mem_write"}, {15'b0, bus.mem_write}, {15'b0, mw});
        chk({tag, ".mem_read"},  {15'b0, bus.mem_read}, {15'b0, mr});
        chk({tag, ".mem_addr"},  bus.mem_addr, addr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
        chk({tag, ".sp_next"},   bus.sp_next, spn);
        chk({tag, ".sp_we"},     {15'b0, bus.sp_we}, {15'b0, spwe});
        chk({tag, ".pc_load"},   {15'b0, bus.pc_load}, {15'b0, pcl});
        chk({tag, ".pc_value"},  bus.pc_value, pcv);
    endtask

    task automatic chk_idle(input string tag);
        chk_step(tag, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    // One clock: the environment reacts to what the block drove in the cycle
    // that is ending (write, 1-cycle read latency, SP and PC registers).
    task automatic cycle();
        lat_wr    = bus.mem_write;
        lat_rd    = bus.mem_read;
        lat_addr  = bus.mem_addr;
        lat_wdata = bus.mem_wdata;
        lat_spwe  = bus.sp_we;
        lat_spn   = bus.sp_next;
        lat_pcl   = bus.pc_load;
        lat_pcv   = bus.pc_value;
        @(posedge clk);
        #1;
        if (lat_wr)   mem[lat_addr] = lat_wdata;
        bus.mem_data_in = lat_rd ? mem[lat_addr] : 16'h0000;
        if (lat_spwe) bus.sp = lat_spn;
        if (lat_pcl)  bus.pc_current = lat_pcv;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        rst             = 1'b1;
        bus.interrupt   = 1'b0;
        bus.rti_req     = 1'b0;
        bus.pc_current  = 16'h0000;
        bus.flags       = 3'b000;
        bus.sp          = 16'h0000;
        bus.mem_data_in = 16'h0000;
        cycle();
        cycle();
        chk_idle("reset_hold");
        rst = 1'b0;
        cycle();
        chk_idle("after_reset");

        // Interrupt entry with pc 0105, flags 101, sp 07FF.
        bus.pc_current = 16'h0105; bus.flags = 3'b101; bus.sp = 16'h07FF;
        bus.interrupt = 1'b1;
        cycle();
        bus.interrupt = 1'b0;
        chk_idle("int_pending");
        cycle(); chk_step("save1", 3'd1, 3'd1, 1, 0, 16'h07FF, 16'h0005, 16'h07FE, 1, 0, 16'h0000);
        cycle(); chk_step("save2", 3'd1, 3'd2, 1, 0, 16'h07FE, 16'h0105, 16'h07FD, 1, 0, 16'h0000);
        cycle(); chk_step("save3", 3'd1, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0020);
        cycle(); chk_step("save4", 3'd1, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("save_done");
        chk("save_mem07FF", mem[16'h07FF], 16'h0005);
        chk("save_mem07FE", mem[16'h07FE], 16'h0105);
        chk("save_sp", bus.sp, 16'h07FD);
        chk("save_pc", bus.pc_current, 16'h0020);

        // RTI from sp 07FD restores pc 0105 and flags 0005.
        bus.flags = 3'b000;
        bus.rti_req = 1'b1;
        cycle();
        bus.rti_req = 1'b0;
        chk_idle("rti_pending");
        cycle(); chk_step("rest1", 3'd2, 3'd1, 0, 1, 16'h07FE, 16'h0000, 16'h07FE, 1, 0, 16'h0000);
        cycle(); chk_step("rest2", 3'd2, 3'd2, 0, 1, 16'h07FF, 16'h0000, 16'h07FF, 1, 0, 16'h0000);
        chk("rest2_pc_bus", bus.mem_data_in, 16'h0105);
        cycle(); chk_step("rest3", 3'd2, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0105);
        chk("rest3_flag_bus", bus.mem_data_in, 16'h0005);
        cycle(); chk_step("rest4", 3'd2, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("rest_done");
        chk("rest_sp", bus.sp, 16'h07FF);
        chk("rest_pc", bus.pc_current, 16'h0105);

        // Both requests in one cycle: SAVE, one IDLE cycle, then RESTORE.
        bus.pc_current = 16'h0200; bus.flags = 3'b010; bus.sp = 16'h0100;
        bus.interrupt = 1'b1; bus.rti_req = 1'b1;
        cycle();
        bus.interrupt = 1'b0; bus.rti_req = 1'b0;
        chk_idle("both_pending");
        cycle(); chk_step("both_s1", 3'd1, 3'd1, 1, 0, 16'h0100, 16'h0002, 16'h00FF, 1, 0, 16'h0000);
        cycle(); chk_step("both_s2", 3'd1, 3'd2, 1, 0, 16'h00FF, 16'h0200, 16'h00FE, 1, 0, 16'h0000);
        cycle(); chk_step("both_s3", 3'd1, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0020);
        cycle(); chk_step("both_s4", 3'd1, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("both_gap");
        cycle(); chk_step("both_r1", 3'd2, 3'd1, 0, 1, 16'h00FF, 16'h0000, 16'h00FF, 1, 0, 16'h0000);
        cycle(); chk_step("both_r2", 3'd2, 3'd2, 0, 1, 16'h0100, 16'h0000, 16'h0100, 1, 0, 16'h0000);
        cycle(); chk_step("both_r3", 3'd2, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0200);
        chk("both_flag_bus", bus.mem_data_in, 16'h0002);
        cycle(); chk_step("both_r4", 3'd2, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("both_done");
        chk("both_sp", bus.sp, 16'h0100);

        // rti_req arriving during SAVE cnt2 is held until after cnt4 + IDLE.
        bus.pc_current = 16'h0AAA; bus.flags = 3'b001; bus.sp = 16'h0300;
        bus.interrupt = 1'b1;
        cycle();
        bus.interrupt = 1'b0;
        cycle(); chk_step("mid_s1", 3'd1, 3'd1, 1, 0, 16'h0300, 16'h0001, 16'h02FF, 1, 0, 16'h0000);
        cycle(); chk_step("mid_s2", 3'd1, 3'd2, 1, 0, 16'h02FF, 16'h0AAA, 16'h02FE, 1, 0, 16'h0000);
        bus.rti_req = 1'b1;
        cycle();
        bus.rti_req = 1'b0;
        chk_step("mid_s3", 3'd1, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0020);
        cycle(); chk_step("mid_s4", 3'd1, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("mid_gap");
        cycle(); chk_step("mid_r1", 3'd2, 3'd1, 0, 1, 16'h02FF, 16'h0000, 16'h02FF, 1, 0, 16'h0000);
        cycle(); chk_step("mid_r2", 3'd2, 3'd2, 0, 1, 16'h0300, 16'h0000, 16'h0300, 1, 0, 16'h0000);
        cycle(); chk_step("mid_r3", 3'd2, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0AAA);
        chk("mid_flag_bus", bus.mem_data_in, 16'h0001);
        cycle(); chk_step("mid_r4", 3'd2, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("mid_done");

        // Asynchronous reset in the middle of RESTORE cnt2; no resumption.
        bus.rti_req = 1'b1;
        cycle();
        bus.rti_req = 1'b0;
        cycle(); chk_step("rst_r1", 3'd2, 3'd1, 0, 1, 16'h0301, 16'h0000, 16'h0301, 1, 0, 16'h0000);
        cycle(); chk_step("rst_r2", 3'd2, 3'd2, 0, 1, 16'h0302, 16'h0000, 16'h0302, 1, 0, 16'h0000);
        #1;
        rst = 1'b1;
        #1;
        chk_idle("rst_async");
        cycle();
        chk_idle("rst_held");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk_idle("rst_after");
        end

        // SP wrap at 0000.
        bus.pc_current = 16'h1234; bus.flags = 3'b110; bus.sp = 16'h0000;
        bus.interrupt = 1'b1;
        cycle();
        bus.interrupt = 1'b0;
        cycle(); chk_step("wrap_s1", 3'd1, 3'd1, 1, 0, 16'h0000, 16'h0006, 16'hFFFF, 1, 0, 16'h0000);
        cycle(); chk_step("wrap_s2", 3'd1, 3'd2, 1, 0, 16'hFFFF, 16'h1234, 16'hFFFE, 1, 0, 16'h0000);
        cycle(); chk_step("wrap_s3", 3'd1, 3'd3, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0020);
        cycle(); chk_step("wrap_s4", 3'd1, 3'd4, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000);
        cycle(); chk_idle("wrap_done");
        chk("wrap_mem0000", mem[16'h0000], 16'h0006);
        chk("wrap_memFFFF", mem[16'hFFFF], 16'h1234);
        chk("wrap_sp", bus.sp, 16'hFFFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
